// File: rtl/bus_arbiter_mux_if.sv
// Bus-source selector interface: NSRC flattened sources and drive strobes in,
// one registered WIDTH-bit bus plus conflict debug status out.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 32,
  parameter int SELW  = $clog2(NSRC)
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       drive_req;
  logic                  hold;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_sel;
  logic                  conflict;
  logic [7:0]            conflict_cnt;

  // bus_valid qualifies bus_out/bus_sel for the current cycle; there is no
  // ready: the only back-pressure is hold, which freezes the bus in place.
  modport master (
    output src_data, drive_req, hold, conflict_clr,
    input  bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, drive_req, hold, conflict_clr,
    output bus_out, bus_valid, bus_sel, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Registered NSRC-to-1 bus selector driven by per-source drive strobes, with
// fixed-priority or round-robin arbitration and multiple-driver detection.
module bus_arbiter_mux #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 32,
  parameter int SELW      = $clog2(NSRC),
  parameter int RR_MODE   = 0,
  parameter int ZERO_IDLE = 1
) (
  input  logic                clk,
  input  logic                clear,
  bus_arbiter_mux_if.slave    bus
);

  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_valid;
  logic [SELW-1:0]  r_bus_sel;
  logic [SELW-1:0]  r_last_grant;
  logic             r_conflict;
  logic [7:0]       r_conflict_cnt;

  logic             w_any;
  logic             w_multi;
  logic             w_rr_found;
  logic [SELW-1:0]  w_grant;
  logic [WIDTH-1:0] w_data;
  int               w_idx;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign w_any   = |bus.drive_req;
  assign w_multi = (bus.drive_req & (bus.drive_req - 1'b1)) != '0;

  always_comb begin
    w_grant    = '0;
    w_rr_found = 1'b0;
    w_idx      = 0;
    if (RR_MODE == 0) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (bus.drive_req[i]) w_grant = SELW'(i);
      end
    end else begin
      // Rotating search starting just after the last winner.
      for (int k = 1; k <= NSRC; k++) begin
        w_idx = (int'(r_last_grant) + k) % NSRC;
        if (!w_rr_found && bus.drive_req[w_idx]) begin
          w_grant    = SELW'(w_idx);
          w_rr_found = 1'b1;
        end
      end
    end
  end

  assign w_data = bus.src_data[int'(w_grant)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      r_bus_out      <= '0;
      r_bus_valid    <= 1'b0;
      r_bus_sel      <= '0;
      r_last_grant   <= SELW'(NSRC - 1);
      r_conflict     <= 1'b0;
      r_conflict_cnt <= 8'd0;
    end else begin
      if (!bus.hold) begin
        if (w_any) begin
          r_bus_out    <= w_data;
          r_bus_sel    <= w_grant;
          r_bus_valid  <= 1'b1;
          r_last_grant <= w_grant;
        end else begin
          r_bus_valid <= 1'b0;
          if (ZERO_IDLE != 0) r_bus_out <= '0;
        end
      end
      // Conflict tracking runs through hold; a new conflict beats a clear.
      if (w_multi) begin
        r_conflict <= 1'b1;
        if (bus.conflict_clr)
          r_conflict_cnt <= 8'd1;
        else if (r_conflict_cnt != 8'hFF)
          r_conflict_cnt <= r_conflict_cnt + 8'd1;
      end else if (bus.conflict_clr) begin
        r_conflict     <= 1'b0;
        r_conflict_cnt <= 8'd0;
      end
    end
  end

  assign bus.bus_out      = r_bus_out;
  assign bus.bus_valid    = r_bus_valid;
  assign bus.bus_sel      = r_bus_sel;
  assign bus.conflict     = r_conflict;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: three configurations share one stimulus stream and
// are checked against a list-based reference model plus directed vectors.
module tb_bus_arbiter_mux;

  typedef struct {
    logic [31:0] bus;
    int          sel;
    bit          valid;
    int          last;
    bit          conf;
    int          cnt;
  } mstate_t;

  typedef struct {
    logic [31:0] req;
    bit          hold;
    bit          cclr;
    bit          clr;
    logic [31:0] bus;
    logic        valid;
    int          sel;
    logic        conf;
    int          cnt;
  } vec_t;

  // ---------------- clock / reset / stimulus ----------------
  logic          clk;
  logic          s_clear;
  logic [31:0]   s_req;
  logic [1023:0] s_data;
  logic          s_hold;
  logic          s_cclr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bus_arbiter_mux_if #(.WIDTH(32), .NSRC(32)) if0 ();
  bus_arbiter_mux_if #(.WIDTH(32), .NSRC(4))  if1 ();
  bus_arbiter_mux_if #(.WIDTH(32), .NSRC(32)) if2 ();

  assign if0.drive_req = s_req;
  assign if0.src_data  = s_data;
  assign if0.hold      = s_hold;
  assign if0.conflict_clr = s_cclr;
  assign if1.drive_req = s_req[3:0];
  assign if1.src_data  = s_data[127:0];
  assign if1.hold      = s_hold;
  assign if1.conflict_clr = s_cclr;
  assign if2.drive_req = s_req;
  assign if2.src_data  = s_data;
  assign if2.hold      = s_hold;
  assign if2.conflict_clr = s_cclr;

  bus_arbiter_mux #(.WIDTH(32), .NSRC(32), .RR_MODE(0), .ZERO_IDLE(1))
    dut0 (.clk(clk), .clear(s_clear), .bus(if0.slave));
  bus_arbiter_mux #(.WIDTH(32), .NSRC(4), .RR_MODE(1), .ZERO_IDLE(1))
    dut1 (.clk(clk), .clear(s_clear), .bus(if1.slave));
  bus_arbiter_mux #(.WIDTH(32), .NSRC(32), .RR_MODE(0), .ZERO_IDLE(0))
    dut2 (.clk(clk), .clear(s_clear), .bus(if2.slave));

  // ---------------- reference model ----------------
  mstate_t m0, m1, m2;
  int n_checks;
  int n_fail;

  function automatic mstate_t mstep(mstate_t m, int nsrc, bit rr, bit zi,
                                    logic [31:0] req, logic [1023:0] data,
                                    bit hold, bit cclr, bit clr);
    mstate_t r;
    int reqs[$];
    int g;
    r = m;
    if (clr) begin
      r.bus = 0; r.sel = 0; r.valid = 0; r.last = nsrc - 1; r.conf = 0; r.cnt = 0;
      return r;
    end
    for (int i = 0; i < nsrc; i++) if (req[i]) reqs.push_back(i);
    if (!hold) begin
      if (reqs.size() > 0) begin
        g = reqs[0];
        if (rr) begin
          foreach (reqs[k]) begin
            if (reqs[k] > m.last) begin
              g = reqs[k];
              break;
            end
          end
        end
        r.bus = data[g*32 +: 32]; r.sel = g; r.valid = 1; r.last = g;
      end else begin
        r.valid = 0;
        if (zi) r.bus = 0;
      end
    end
    if (reqs.size() >= 2) begin
      r.conf = 1;
      r.cnt  = cclr ? 1 : ((m.cnt < 255) ? m.cnt + 1 : 255);
    end else if (cclr) begin
      r.conf = 0; r.cnt = 0;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag, input mstate_t m, input logic [31:0] bus,
                           input logic valid, input logic [31:0] sel,
                           input logic conf, input logic [7:0] cnt);
    chk({tag, "_bus"},   bus,          m.bus);
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, m.valid});
    chk({tag, "_sel"},   sel,          32'(m.sel));
    chk({tag, "_conf"},  {31'd0, conf},  {31'd0, m.conf});
    chk({tag, "_cnt"},   {24'd0, cnt},   32'(m.cnt));
  endtask

  // One clock: models consume the inputs sampled at this edge, then compare.
  task automatic step();
    @(posedge clk);
    m0 = mstep(m0, 32, 1'b0, 1'b1, s_req, s_data, s_hold, s_cclr, s_clear);
    m1 = mstep(m1, 4,  1'b1, 1'b1, s_req, s_data, s_hold, s_cclr, s_clear);
    m2 = mstep(m2, 32, 1'b0, 1'b0, s_req, s_data, s_hold, s_cclr, s_clear);
    #1;
    chk_model("d0", m0, if0.bus_out, if0.bus_valid, {27'd0, if0.bus_sel}, if0.conflict, if0.conflict_cnt);
    chk_model("d1", m1, if1.bus_out, if1.bus_valid, {30'd0, if1.bus_sel}, if1.conflict, if1.conflict_cnt);
    chk_model("d2", m2, if2.bus_out, if2.bus_valid, {27'd0, if2.bus_sel}, if2.conflict, if2.conflict_cnt);
  endtask

  task automatic drive(input logic [31:0] req, input bit hold, input bit cclr, input bit clr);
    s_req = req; s_hold = hold; s_cclr = cclr; s_clear = clr;
  endtask

  vec_t tbl[16];
  logic [1:0] exp_q[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) s_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // ---------------- directed vectors (fixed priority, ZERO_IDLE=1) ----------------
    //            req           hold cclr clr  bus           v  sel conf cnt
    tbl[0]  = '{32'hFFFF_FFFF, 1, 0, 1, 32'h0000_0000, 0, 0,  0, 0};
    tbl[1]  = '{32'h0000_0020, 0, 0, 0, 32'hA000_0005, 1, 5,  0, 0};
    tbl[2]  = '{32'h0008_0000, 0, 0, 0, 32'hA000_0013, 1, 19, 0, 0};
    tbl[3]  = '{32'h0000_0000, 0, 0, 0, 32'h0000_0000, 0, 19, 0, 0};
    tbl[4]  = '{32'h0010_0008, 0, 0, 0, 32'hA000_0003, 1, 3,  1, 1};
    tbl[5]  = '{32'h0010_0008, 0, 0, 0, 32'hA000_0003, 1, 3,  1, 2};
    tbl[6]  = '{32'h0010_0008, 0, 0, 0, 32'hA000_0003, 1, 3,  1, 3};
    tbl[7]  = '{32'h0000_0000, 0, 1, 0, 32'h0000_0000, 0, 3,  0, 0};
    tbl[8]  = '{32'h0000_0006, 0, 1, 0, 32'hA000_0001, 1, 1,  1, 1};
    tbl[9]  = '{32'h0000_0080, 0, 0, 0, 32'hA000_0007, 1, 7,  1, 1};
    tbl[10] = '{32'h0000_0200, 1, 0, 0, 32'hA000_0007, 1, 7,  1, 1};
    tbl[11] = '{32'h0000_0200, 1, 0, 0, 32'hA000_0007, 1, 7,  1, 1};
    tbl[12] = '{32'h0000_0200, 1, 0, 0, 32'hA000_0007, 1, 7,  1, 1};
    tbl[13] = '{32'h0000_0200, 1, 0, 0, 32'hA000_0007, 1, 7,  1, 1};
    tbl[14] = '{32'h0000_0200, 0, 0, 0, 32'hA000_0009, 1, 9,  1, 1};
    tbl[15] = '{32'h0000_0000, 0, 1, 0, 32'h0000_0000, 0, 9,  0, 0};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].req, tbl[i].hold, tbl[i].cclr, tbl[i].clr);
      step();
      chk($sformatf("v%0d_bus", i),   if0.bus_out, tbl[i].bus);
      chk($sformatf("v%0d_valid", i), {31'd0, if0.bus_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("v%0d_sel", i),   {27'd0, if0.bus_sel}, 32'(tbl[i].sel));
      chk($sformatf("v%0d_conf", i),  {31'd0, if0.conflict}, {31'd0, tbl[i].conf});
      chk($sformatf("v%0d_cnt", i),   {24'd0, if0.conflict_cnt}, 32'(tbl[i].cnt));
    end

    // ---------------- round-robin fairness on the 4-source instance ----------------
    drive(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    step();
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 7; i++) begin
      drive((i < 6) ? 32'h0000_000B : 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("rr%0d_sel", i), {30'd0, if1.bus_sel}, {30'd0, exp_q.pop_front()});
      chk($sformatf("rr%0d_valid", i), {31'd0, if1.bus_valid}, 32'd1);
    end

    // ---------------- counter saturation and ZERO_IDLE=0 hold-last ----------------
    drive(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 300; i++) begin
      drive(32'h0000_0003, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat_cnt", {24'd0, if2.conflict_cnt}, 32'd255);
    chk("sat_conf", {31'd0, if2.conflict}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      drive(32'h0000_0000, 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("idle%0d_valid", i), {31'd0, if2.bus_valid}, 32'd0);
      chk($sformatf("idle%0d_bus", i), if2.bus_out, 32'hA000_0000);
      chk($sformatf("idle%0d_zi_bus", i), if0.bus_out, 32'h0000_0000);
    end

    // ---------------- randomized traffic against the model ----------------
    for (int i = 0; i < 600; i++) begin
      logic [31:0] req;
      case ($urandom_range(0, 3))
        0:       req = 32'h0;
        1:       req = 32'h1 << $urandom_range(0, 31);
        2:       req = $urandom;
        default: req = $urandom & $urandom & $urandom;
      endcase
      for (int w = 0; w < 32; w++) s_data[w*32 +: 32] = $urandom;
      drive(req, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 49) == 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
